// File: rtl/fifo_package.sv
// Shared sizing for the FIFO storage array and its controller.
package fifo_package;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/sp_sram.sv
// Single-port RAM holding the FIFO words: one access per cycle, read-first on writes,
// registered read data one clock after the address.
module sp_sram #(
  parameter int DATA_WIDTH = fifo_package::DATA_WIDTH,
  parameter int DEPTH      = fifo_package::DEPTH,
  parameter int ADDR_WIDTH = fifo_package::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Access semantics: addr_i/we_i/wdata_i are sampled every rising edge; there is no
  // valid/ready pair, so the controller must hold a read address until it takes rdata_o.

  if (DEPTH < 2) begin : g_depth_check
    $error("sp_sram: DEPTH must be at least 2");
  end
  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_addr_check
    $error("sp_sram: ADDR_WIDTH too narrow for DEPTH");
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;

  // Only reachable as false when DEPTH is not a power of two.
  assign in_range = ({1'b0, addr_i} < DEPTH_L);

  // Storage is never cleared, so it stays a plain RAM without a reset path.
  always_ff @(posedge clk) begin
    if (!rst && we_i && in_range) begin
      mem[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_o <= '0;
    end else if (in_range) begin
      rdata_o <= mem[addr_i];
    end else begin
      rdata_o <= '0;
    end
  end

endmodule

// File: tb/tb_sp_sram.sv
// Directed and random checks of sp_sram at DEPTH=16 and DEPTH=12 against an array model.
module tb_sp_sram;
  import fifo_package::*;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, we_a, rst_b, we_b;
  logic [3:0]  addr_a, addr_b;
  word_t       wdata_a, rdata_a, wdata_b, rdata_b;

  sp_sram #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .addr_i(addr_a), .wdata_i(wdata_a), .we_i(we_a), .rdata_o(rdata_a)
  );

  sp_sram #(.DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .addr_i(addr_b), .wdata_i(wdata_b), .we_i(we_b), .rdata_o(rdata_b)
  );

  // scoreboard: reference contents, written flags, expected read data queue
  word_t model_a [16];
  word_t model_b [16];
  bit    known_a [16];
  bit    known_b [16];
  logic [31:0] exp_q[$];
  bit          exp_known_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural expectation: reset -> 0; out of range -> 0 and no write;
  // otherwise old contents come out and the new word is stored.
  task automatic model_step(input bit sel, input bit rst, input bit we, input int addr,
                            input word_t data);
    int    depth;
    word_t e;
    bit    k;
    depth = sel ? 12 : 16;
    if (rst) begin
      e = '0; k = 1'b1;
    end else if (addr >= depth) begin
      e = '0; k = 1'b1;
    end else begin
      e = sel ? model_b[addr] : model_a[addr];
      k = sel ? known_b[addr] : known_a[addr];
      if (we) begin
        if (sel) begin model_b[addr] = data; known_b[addr] = 1'b1; end
        else     begin model_a[addr] = data; known_a[addr] = 1'b1; end
      end
    end
    exp_q.push_back(e);
    exp_known_q.push_back(k);
  endtask

  // driver: one access per cycle, inputs on the falling edge, sample 1 time unit after rising
  task automatic op(input bit sel, input bit rst, input bit we, input int addr,
                    input word_t data, input string tag, output word_t obs);
    word_t e;
    bit    k;
    @(negedge clk);
    rst_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    rst_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    if (sel) begin rst_b = rst; we_b = we; addr_b = 4'(addr); wdata_b = data; end
    else     begin rst_a = rst; we_a = we; addr_a = 4'(addr); wdata_a = data; end
    model_step(sel, rst, we, addr, data);
    @(posedge clk);
    #1;
    obs = sel ? rdata_b : rdata_a;
    e = exp_q.pop_front();
    k = exp_known_q.pop_front();
    if (k) chk(tag, obs, e);
  endtask

  initial begin
    word_t r;
    rst_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    rst_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    for (int i = 0; i < 16; i++) begin
      known_a[i] = 1'b0; known_b[i] = 1'b0; model_a[i] = '0; model_b[i] = '0;
    end

    // reset with a write request pending
    op(0, 1, 1, 3, 32'hDEAD, "reset0", r);
    chk("reset0_zero", r, 32'h0);
    op(0, 1, 1, 3, 32'hDEAD, "reset1", r);
    chk("reset1_zero", r, 32'h0);
    op(1, 1, 1, 3, 32'hDEAD, "reset_b", r);
    op(0, 0, 0, 3, '0, "reset_noread", r);
    checks++;
    assert (r !== 32'hDEAD) else begin
      failures++;
      $error("FAIL reset_nowrite observed=%h expected=not DEAD", r);
    end

    // write/read at both ends
    op(0, 0, 1, 0, 32'hA5A5_0001, "wr0", r);
    op(0, 0, 1, 15, 32'hA5A5_000F, "wr15", r);
    op(0, 0, 0, 0, '0, "rd0", r);
    chk("rd0_const", r, 32'hA5A5_0001);
    op(0, 0, 0, 15, '0, "rd15", r);
    chk("rd15_const", r, 32'hA5A5_000F);

    // read-first on back-to-back writes
    op(0, 0, 1, 5, 32'h1111, "rf_w1", r);
    op(0, 0, 1, 5, 32'h2222, "rf_w2", r);
    chk("rf_old", r, 32'h1111);
    op(0, 0, 0, 5, '0, "rf_rd", r);
    chk("rf_new", r, 32'h2222);

    // full sweep
    for (int a = 0; a < 16; a++) op(0, 0, 1, a, 32'(a * 3 + 7), "sweep_wr", r);
    for (int a = 0; a < 16; a++) begin
      op(0, 0, 0, a, '0, "sweep_rd", r);
      chk("sweep_const", r, 32'(a * 3 + 7));
    end

    // reset during a read, contents retained
    op(0, 1, 0, 7, '0, "mid_rst", r);
    chk("mid_rst_zero", r, 32'h0);
    op(0, 0, 0, 7, '0, "mid_rd7", r);
    chk("mid_rd7_const", r, 32'd28);

    // DEPTH=12: out-of-range write dropped, read returns 0
    op(1, 0, 1, 2, 32'h1234, "b_wr2", r);
    op(1, 0, 1, 13, 32'hBEEF, "b_wr13", r);
    chk("b_wr13_zero", r, 32'h0);
    op(1, 0, 0, 13, '0, "b_rd13", r);
    chk("b_rd13_zero", r, 32'h0);
    op(1, 0, 0, 2, '0, "b_rd2", r);
    chk("b_rd2_const", r, 32'h1234);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      op(0, ($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 15),
         $urandom, "rand_a", r);
    end
    for (int i = 0; i < 200; i++) begin
      op(1, ($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 15),
         $urandom, "rand_b", r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
